// File: rtl/nmos_clk_gen_pkg.sv
// Shared types and constants for the two-phase NMOS clock generator:
// the phase enum, default lengths and the phase-length legality check.
package nmos_clk_pkg;

  typedef enum logic [1:0] {
    PHI1  = 2'd0,
    GAP12 = 2'd1,
    PHI2  = 2'd2,
    GAP21 = 2'd3
  } phase_e;

  localparam int DEF_P1_LEN  = 2;
  localparam int DEF_P2_LEN  = 2;
  localparam int DEF_GAP_LEN = 1;
  localparam int DEF_CNT_W   = 4;
  localparam int DEF_CYC_W   = 16;

  // A length must fit a CNT_W timer loaded with len-1, and zero is never legal.
  function automatic bit len_legal(input int len, input int cnt_w);
    return (len >= 1) && (len <= (1 << cnt_w) - 1);
  endfunction

endpackage

// File: rtl/nmos_clk_gen_if.sv
// Halt control and clock-output bundle of nmos_clk_gen.
// NMOS_CLKGEN_STEP_EN adds the single-step request STEP.
interface nmos_clk_gen_if #(
  parameter int CYC_W = 16
);
  logic             HALT;
`ifdef NMOS_CLKGEN_STEP_EN
  logic             STEP;
`endif
  logic             C1;
  logic             C2;
  logic             C1_RISE;
  logic             C2_FALL;
  logic             HALTED;
  logic [CYC_W-1:0] CYC_CNT;

`ifdef NMOS_CLKGEN_STEP_EN
  modport master (input HALT, input STEP,
                  output C1, output C2, output C1_RISE, output C2_FALL,
                  output HALTED, output CYC_CNT);
  modport slave  (output HALT, output STEP,
                  input C1, input C2, input C1_RISE, input C2_FALL,
                  input HALTED, input CYC_CNT);
`else
  modport master (input HALT,
                  output C1, output C2, output C1_RISE, output C2_FALL,
                  output HALTED, output CYC_CNT);
  modport slave  (output HALT,
                  input C1, input C2, input C1_RISE, input C2_FALL,
                  input HALTED, input CYC_CNT);
`endif
endinterface

// File: rtl/nmos_clk_gen_phase_timer.sv
// Phase timer: CNT_W down-counter with load, hold and terminal count.
// It has no reset of its own; the owner loads it during reset.
module nmos_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             main_clk,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             hold,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (!hold && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge main_clk) begin
    cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == '0);

endmodule

// File: rtl/nmos_clk_gen.sv
// Two-phase non-overlapping clock generator (PHI1/PHI2 on C1/C2) with halt and cycle count.
// Optional single-step release while halted: define NMOS_CLKGEN_STEP_EN.
module nmos_clk_gen
  import nmos_clk_pkg::*;
#(
  parameter int P1_LEN  = DEF_P1_LEN,
  parameter int P2_LEN  = DEF_P2_LEN,
  parameter int GAP_LEN = DEF_GAP_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int CYC_W   = DEF_CYC_W
) (
  input  logic           main_clk,
  input  logic           R,
  nmos_clk_gen_if.master bus
);

  if (!len_legal(P1_LEN, CNT_W) || !len_legal(P2_LEN, CNT_W) ||
      !len_legal(GAP_LEN, CNT_W)) begin : g_bad_len
    $error("nmos_clk_gen: P1_LEN/P2_LEN/GAP_LEN must be in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] P1_LD  = CNT_W'(P1_LEN - 1);
  localparam logic [CNT_W-1:0] P2_LD  = CNT_W'(P2_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_LEN - 1);

  phase_e           state_d, state_q;
  logic             halted_d, halted_q;
  logic [CYC_W-1:0] cyc_d, cyc_q;
  logic             c1_d, c1_q, c2_d, c2_q;
  logic             c1_rise_d, c1_rise_q, c2_fall_d, c2_fall_q;
  logic             tmr_load, tmr_hold, tmr_tc;
  logic [CNT_W-1:0] tmr_val;
  logic             release_req;

  // A parked generator leaves GAP21 on HALT low, or on a step request.
`ifdef NMOS_CLKGEN_STEP_EN
  assign release_req = !bus.HALT || bus.STEP;
`else
  assign release_req = !bus.HALT;
`endif

  nmos_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .main_clk (main_clk),
    .load     (tmr_load),
    .load_val (tmr_val),
    .hold     (tmr_hold),
    .tc       (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    cyc_d    = cyc_q;
    tmr_load = 1'b0;
    tmr_hold = 1'b0;
    tmr_val  = GAP_LD;
    if (tmr_tc) begin
      tmr_load = 1'b1;
      unique case (state_q)
        PHI1: begin
          state_d = GAP12;
          tmr_val = GAP_LD;
        end
        GAP12: begin
          state_d = PHI2;
          tmr_val = P2_LD;
        end
        PHI2: begin
          state_d = GAP21;
          tmr_val = GAP_LD;
          cyc_d   = cyc_q + CYC_W'(1);
        end
        GAP21: begin
          if (halted_q ? release_req : !bus.HALT) begin
            state_d  = PHI1;
            tmr_val  = P1_LD;
            halted_d = 1'b0;
          end else begin
            tmr_load = 1'b0;
            tmr_hold = 1'b1;
            halted_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // Reset reloads the timer as if GAP21 had just been entered.
    if (R) begin
      tmr_load = 1'b1;
      tmr_hold = 1'b0;
      tmr_val  = GAP_LD;
    end
    c1_d      = (state_d == PHI1);
    c2_d      = (state_d == PHI2);
    c1_rise_d = (state_d == PHI1) && (state_q != PHI1);
    c2_fall_d = (state_d == GAP21) && (state_q == PHI2);
  end

  always_ff @(posedge main_clk) begin
    if (R) begin
      state_q   <= GAP21;
      halted_q  <= 1'b0;
      cyc_q     <= '0;
      c1_q      <= 1'b0;
      c2_q      <= 1'b0;
      c1_rise_q <= 1'b0;
      c2_fall_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      halted_q  <= halted_d;
      cyc_q     <= cyc_d;
      c1_q      <= c1_d;
      c2_q      <= c2_d;
      c1_rise_q <= c1_rise_d;
      c2_fall_q <= c2_fall_d;
    end
  end

  assign bus.C1      = c1_q;
  assign bus.C2      = c2_q;
  assign bus.C1_RISE = c1_rise_q;
  assign bus.C2_FALL = c2_fall_q;
  assign bus.HALTED  = halted_q;
  assign bus.CYC_CNT = cyc_q;

endmodule

// File: tb/tb_nmos_clk_gen.sv
// Bench for nmos_clk_gen: three configurations driven in lockstep and checked
// against a position-in-period reference model.
module tb_nmos_clk_gen;

  localparam int ND = 3;
`ifdef NMOS_CLKGEN_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  // dut 0: defaults; dut 1: P1=3 P2=1 GAP=2; dut 2: defaults with CYC_W=4
  function automatic int p1_of(int d);  return (d == 1) ? 3 : 2; endfunction
  function automatic int p2_of(int d);  return (d == 1) ? 1 : 2; endfunction
  function automatic int gap_of(int d); return (d == 1) ? 2 : 1; endfunction
  function automatic int cw_of(int d);  return (d == 2) ? 4 : 16; endfunction

  logic main_clk = 1'b0;
  logic R = 1'b1;
  logic HALT = 1'b0;
`ifdef NMOS_CLKGEN_STEP_EN
  logic STEP = 1'b0;
`endif
  always #5 main_clk = ~main_clk;

  nmos_clk_gen_if #(.CYC_W(16)) if_a ();
  nmos_clk_gen_if #(.CYC_W(16)) if_b ();
  nmos_clk_gen_if #(.CYC_W(4))  if_c ();
  assign if_a.HALT = HALT;
  assign if_b.HALT = HALT;
  assign if_c.HALT = HALT;
`ifdef NMOS_CLKGEN_STEP_EN
  assign if_a.STEP = STEP;
  assign if_b.STEP = STEP;
  assign if_c.STEP = STEP;
`endif

  nmos_clk_gen #(.P1_LEN(2), .P2_LEN(2), .GAP_LEN(1), .CNT_W(4), .CYC_W(16)) dut_a (
    .main_clk(main_clk), .R(R), .bus(if_a));
  nmos_clk_gen #(.P1_LEN(3), .P2_LEN(1), .GAP_LEN(2), .CNT_W(4), .CYC_W(16)) dut_b (
    .main_clk(main_clk), .R(R), .bus(if_b));
  nmos_clk_gen #(.P1_LEN(2), .P2_LEN(2), .GAP_LEN(1), .CNT_W(4), .CYC_W(4)) dut_c (
    .main_clk(main_clk), .R(R), .bus(if_c));

  // Model: pos is the cycle's position within the period, 0 = first PHI1 cycle,
  // period-1 = last GAP21 cycle (the only place the generator can park).
  typedef struct {
    int pos;
    bit halted;
    bit rise;
    bit fall;
    int cyc;
  } mdl_t;

  mdl_t        m   [ND];
  logic [20:0] got [ND];
  int tests = 0;
  int fails = 0;

  function automatic mdl_t mdl_step(mdl_t s, int d, bit r, bit h, bit st);
    mdl_t n;
    int   per;
    int   fall_pos;
    n        = s;
    per      = p1_of(d) + p2_of(d) + 2 * gap_of(d);
    fall_pos = p1_of(d) + gap_of(d) + p2_of(d);
    n.rise   = 1'b0;
    n.fall   = 1'b0;
    if (r) begin
      n.pos    = per - gap_of(d);
      n.halted = 1'b0;
      n.cyc    = 0;
      return n;
    end
    if (s.pos == per - 1) begin
      if (s.halted) begin
        if (!h || (STEP_EN && st)) begin
          n.halted = 1'b0;
          n.pos    = 0;
        end
      end else if (h) begin
        n.halted = 1'b1;
      end else begin
        n.pos = 0;
      end
    end else begin
      n.pos = s.pos + 1;
    end
    if (n.pos != s.pos) begin
      n.rise = (n.pos == 0);
      if (n.pos == fall_pos) begin
        n.fall = 1'b1;
        n.cyc  = (s.cyc + 1) % (1 << cw_of(d));
      end
    end
    return n;
  endfunction

  function automatic logic [20:0] mdl_out(mdl_t s, int d);
    logic c1, c2;
    c1 = (s.pos < p1_of(d));
    c2 = (s.pos >= p1_of(d) + gap_of(d)) && (s.pos < p1_of(d) + gap_of(d) + p2_of(d));
    return {c1, c2, s.rise, s.fall, s.halted, s.cyc[15:0]};
  endfunction

  // Drive inputs for the coming edge, advance the models, sample 1 time unit later.
  task automatic step_cycle(input bit r, input bit h, input bit st);
    R    = r;
    HALT = h;
`ifdef NMOS_CLKGEN_STEP_EN
    STEP = st;
`endif
    @(posedge main_clk);
    for (int d = 0; d < ND; d++) m[d] = mdl_step(m[d], d, r, h, st);
    #1;
    got[0] = {if_a.C1, if_a.C2, if_a.C1_RISE, if_a.C2_FALL, if_a.HALTED, if_a.CYC_CNT};
    got[1] = {if_b.C1, if_b.C2, if_b.C1_RISE, if_b.C2_FALL, if_b.HALTED, if_b.CYC_CNT};
    got[2] = {if_c.C1, if_c.C2, if_c.C1_RISE, if_c.C2_FALL, if_c.HALTED, 12'd0, if_c.CYC_CNT};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step_cycle(1'b1, 1'b0, 1'b0);
      for (int d = 0; d < ND; d++) begin
        tests++;
        if (got[d] !== 21'd0) begin
          fails++;
          $display("FAIL reset_state dut%0d got=%b required=%b", d, got[d], 21'd0);
        end
      end
    end
  endtask

  task automatic test_defaults();
    int rises [ND];
    for (int d = 0; d < ND; d++) rises[d] = 0;
    for (int i = 0; i < 24; i++) begin
      step_cycle(1'b0, 1'b0, 1'b0);
      if (i == 0) begin
        tests++;
        if (got[0][20:18] !== 3'b101) begin
          fails++;
          $display("FAIL first_c1_edge dut0 got C1,C2,RISE=%b required=101", got[0][20:18]);
        end
      end
      for (int d = 0; d < ND; d++) begin
        rises[d] += int'(got[d][18]);
        tests++;
        if (got[d] !== mdl_out(m[d], d)) begin
          fails++;
          $display("FAIL defaults_seq dut%0d t=%0t got=%b required=%b", d, $time, got[d], mdl_out(m[d], d));
        end
      end
    end
    tests++;
    if (rises[0] !== 4 || rises[1] !== 3) begin
      fails++;
      $display("FAIL rise_count got dut0=%0d dut1=%0d required 4 and 3", rises[0], rises[1]);
    end
  endtask

  task automatic test_halt();
    int guard;
    guard = 0;
    while (m[0].pos != 0 && guard < 20) begin
      step_cycle(1'b0, 1'b0, 1'b0);
      guard++;
    end
    tests++;
    if (m[0].pos != 0) begin
      fails++;
      $display("FAIL halt_sync wait expired pos=%0d required 0", m[0].pos);
    end
    for (int i = 0; i < 12; i++) begin
      step_cycle(1'b0, 1'b1, 1'b0);
      for (int d = 0; d < ND; d++) begin
        tests++;
        if (got[d] !== mdl_out(m[d], d)) begin
          fails++;
          $display("FAIL halt_seq dut%0d t=%0t got=%b required=%b", d, $time, got[d], mdl_out(m[d], d));
        end
      end
    end
    tests++;
    if (got[0][20:16] !== 5'b00001) begin
      fails++;
      $display("FAIL halted_park dut0 got C1,C2,RISE,FALL,HALTED=%b required=00001", got[0][20:16]);
    end
    step_cycle(1'b0, 1'b0, 1'b0);
    tests++;
    if (got[0][20:16] !== 5'b10100) begin
      fails++;
      $display("FAIL halt_release dut0 got C1,C2,RISE,FALL,HALTED=%b required=10100", got[0][20:16]);
    end
    for (int d = 0; d < ND; d++) begin
      tests++;
      if (got[d] !== mdl_out(m[d], d)) begin
        fails++;
        $display("FAIL release_seq dut%0d got=%b required=%b", d, got[d], mdl_out(m[d], d));
      end
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (m[0].pos != p1_of(0) + gap_of(0) && guard < 20) begin
      step_cycle(1'b0, 1'b0, 1'b0);
      guard++;
    end
    tests++;
    if (got[0][19] !== 1'b1 || got[0][15:0] === 16'd0) begin
      fails++;
      $display("FAIL reset_mid_setup dut0 got C2=%b CYC=%0d required C2=1 and CYC>0", got[0][19], got[0][15:0]);
    end
    step_cycle(1'b1, 1'b0, 1'b0);
    tests++;
    if (got[0] !== 21'd0) begin
      fails++;
      $display("FAIL reset_mid dut0 got=%b required=%b", got[0], 21'd0);
    end
    for (int i = 0; i < 12; i++) begin
      step_cycle(1'b0, 1'b0, 1'b0);
      if (i == 0) begin
        tests++;
        if (got[0][20] !== 1'b1) begin
          fails++;
          $display("FAIL restart_c1 dut0 got C1=%b required=1", got[0][20]);
        end
      end
      for (int d = 0; d < ND; d++) begin
        tests++;
        if (got[d] !== mdl_out(m[d], d)) begin
          fails++;
          $display("FAIL restart_seq dut%0d t=%0t got=%b required=%b", d, $time, got[d], mdl_out(m[d], d));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int  prev;
    bit  saw_wrap;
    bit  saw_one;
    prev     = int'(got[2][3:0]);
    saw_wrap = 1'b0;
    saw_one  = 1'b0;
    for (int i = 0; i < 110; i++) begin
      step_cycle(1'b0, 1'b0, 1'b0);
      if (prev == 15 && got[2][3:0] == 4'd0) saw_wrap = 1'b1;
      if (saw_wrap && got[2][3:0] == 4'd1) saw_one = 1'b1;
      prev = int'(got[2][3:0]);
      for (int d = 0; d < ND; d++) begin
        tests++;
        if (got[d] !== mdl_out(m[d], d)) begin
          fails++;
          $display("FAIL wrap_seq dut%0d t=%0t got=%b required=%b", d, $time, got[d], mdl_out(m[d], d));
        end
      end
    end
    tests++;
    if (!(saw_wrap && saw_one)) begin
      fails++;
      $display("FAIL cyc_wrap dut2 got wrap=%0d then_one=%0d required 1 and 1", saw_wrap, saw_one);
    end
  endtask

`ifdef NMOS_CLKGEN_STEP_EN
  task automatic test_step();
    int guard;
    int rises;
    int cyc0;
    guard = 0;
    while (!m[0].halted && guard < 20) begin
      step_cycle(1'b0, 1'b1, 1'b0);
      guard++;
    end
    cyc0  = m[0].cyc;
    rises = 0;
    for (int i = 0; i < 44; i++) begin
      // Pulses at 0 and 20; the one at 3 lands inside the stepped cycle.
      step_cycle(1'b0, 1'b1, (i == 0) || (i == 3) || (i == 20));
      rises += int'(got[0][18]);
      for (int d = 0; d < ND; d++) begin
        tests++;
        if (got[d] !== mdl_out(m[d], d)) begin
          fails++;
          $display("FAIL step_seq dut%0d t=%0t got=%b required=%b", d, $time, got[d], mdl_out(m[d], d));
        end
      end
    end
    tests++;
    if (rises !== 2 || got[0][15:0] !== 16'((cyc0 + 2) % 65536) || got[0][16] !== 1'b1) begin
      fails++;
      $display("FAIL step_count dut0 got rises=%0d cyc=%0d halted=%b required 2, %0d, 1",
               rises, got[0][15:0], got[0][16], (cyc0 + 2) % 65536);
    end
    step_cycle(1'b0, 1'b0, 1'b0);
  endtask
`endif

  task automatic test_random();
    bit r, h, st;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 99) == 0);
      h  = ($urandom_range(0, 9) < 3);
      st = ($urandom_range(0, 3) == 0);
      step_cycle(r, h, st);
      for (int d = 0; d < ND; d++) begin
        tests++;
        if (got[d] !== mdl_out(m[d], d) || (got[d][20] && got[d][19])) begin
          fails++;
          $display("FAIL random_seq dut%0d t=%0t got=%b required=%b", d, $time, got[d], mdl_out(m[d], d));
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) m[d] = '{pos: 0, halted: 1'b0, rise: 1'b0, fall: 1'b0, cyc: 0};
    test_reset();
    test_defaults();
    test_halt();
    test_reset_mid();
    test_wrap();
`ifdef NMOS_CLKGEN_STEP_EN
    test_step();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
